// File: rtl/nibble_serial_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Used by nibble_serial_adder; optional subtract mode via NIBBLE_SERIAL_SUB_EN.
package nibble_serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } ns_state_t;

  localparam int SLICE_W = 4;

endpackage

// File: rtl/nibble_serial_adder_cla.sv
// four_bit_cla: 4-bit carry-lookahead slice with group propagate/generate.
// Used once by nibble_serial_adder; no configuration macros.
module four_bit_cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out,
  output logic       p_out,
  output logic       g_out
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  // bit-level propagate/generate, lookahead carries and group terms
  always_comb begin
    p = a ^ b;
    g = a & b;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c_in);
    p_out = &p;
    g_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]);
    c_out = g_out | (p_out & c_in);
    s = p ^ c;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit CLA slice per clock.
// Define NIBBLE_SERIAL_SUB_EN to add the Sub port (A-B mode).
module nibble_serial_adder
  import nibble_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic             Sub,
`endif
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             P_all,
  output logic             G_all,
  output logic             Busy,
  output logic             Done
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  ns_state_t        state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             pall_q;
  logic             gall_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] b_in;
  logic             c_init;
  logic [3:0]       sl_s;
  logic             sl_c;
  logic             sl_p;
  logic             sl_g;

`ifdef NIBBLE_SERIAL_SUB_EN
  assign b_in   = Sub ? ~B : B;
  assign c_init = Sub ? 1'b1 : Cin;
`else
  assign b_in   = B;
  assign c_init = Cin;
`endif

  assign a_sh = a_q >> {idx_q, 2'b00};
  assign b_sh = b_q >> {idx_q, 2'b00};

  four_bit_cla u_cla (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .c_in (carry_q),
    .s    (sl_s),
    .c_out(sl_c),
    .p_out(sl_p),
    .g_out(sl_g)
  );

  // merge the current slice result into the partial sum
  always_comb begin
    sum_d = sum_q;
    for (int k = 0; k < NSLICE; k++) begin
      if (idx_q == IW'(k)) sum_d[k*SLICE_W +: SLICE_W] = sl_s;
    end
  end

  // control FSM, slice counter and all registered outputs
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      pall_q  <= 1'b0;
      gall_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            a_q     <= A;
            b_q     <= b_in;
            carry_q <= c_init;
            sum_q   <= '0;
            pall_q  <= 1'b1;
            gall_q  <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= sl_c;
          pall_q  <= pall_q & sl_p;
          gall_q  <= sl_g | (sl_p & gall_q);
          if (idx_q == LAST) begin
            cout_q  <= sl_c;
            ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1])
                     & (sl_s[3] != a_q[WIDTH-1]);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Sum      = sum_q;
  assign Cout     = cout_q;
  assign Overflow = ovf_q;
  assign P_all    = pall_q;
  assign G_all    = gall_q;
  assign Busy     = busy_q;
  assign Done     = done_q;

endmodule
